// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Memory-side responder for the mos6502 core bus. Completes
//               read/write accesses to a byte-wide RAM behind a req/ready
//               handshake with a fixed number of programmable wait states.
//               Optional output register enabled by defining MEM_IOPORT_EN.
// Ports       : clk, rst_n (async, active low)
//               req_i, rw_i (1=READ, 0=WRITE), addr_i[15:0], wdata_i[7:0]
//               rdata_o[7:0] (held until next read completes)
//               ready_o (one-cycle completion pulse)
//               oob_o   (out-of-range flag, pulses with ready_o)
//               io_o[7:0] (only with MEM_IOPORT_EN)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int          RAM_WORDS   = 2048,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [15:0] IO_ADDR     = 16'hFF00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        rw_i,
    input  logic [15:0] addr_i,
    input  logic [7:0]  wdata_i,
    output logic [7:0]  rdata_o,
    output logic        ready_o,
    output logic        oob_o
`ifdef MEM_IOPORT_EN
    ,
    output logic [7:0]  io_o
`endif
);

    localparam int          c_AW        = $clog2(RAM_WORDS);
    localparam logic [16:0] c_RAM_LIMIT = 17'(RAM_WORDS);
    localparam logic [3:0]  c_WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_rw;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_mem [RAM_WORDS];
    logic [7:0]  r_rdata;
    logic        r_oob;
    logic [7:0]  r_io;

    logic        w_accept;
    logic        w_commit;
    logic        w_rw;
    logic [15:0] w_addr;
    logic [7:0]  w_wdata;
    logic        w_is_io;
    logic        w_in_ram;
    logic        w_oob;
    logic [c_AW-1:0] w_idx;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and handshake outputs. A request is accepted in IDLE and
    // also in RESP so back-to-back accesses need no idle bubble. With zero
    // wait states the access commits on the same edge it is accepted.
    // ------------------------------------------------------------------
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_commit = 1'b0;
        ready_o  = (r_state == S_RESP);
        case (r_state)
            S_IDLE, S_RESP: begin
                w_next = S_IDLE;
                if (req_i) begin
                    w_accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        w_next   = S_RESP;
                        w_commit = 1'b1;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_next   = S_RESP;
                    w_commit = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture and wait counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 4'd0;
            r_rw    <= 1'b1;
            r_addr  <= 16'h0000;
            r_wdata <= 8'h00;
        end else if (w_accept) begin
            r_cnt   <= c_WAIT_LOAD;
            r_rw    <= rw_i;
            r_addr  <= addr_i;
            r_wdata <= wdata_i;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Committing from WAIT uses the captured request; a zero-wait commit
    // happens on the capture edge itself, so it takes the live inputs.
    assign w_rw    = (r_state == S_WAIT) ? r_rw    : rw_i;
    assign w_addr  = (r_state == S_WAIT) ? r_addr  : addr_i;
    assign w_wdata = (r_state == S_WAIT) ? r_wdata : wdata_i;

    // ------------------------------------------------------------------
    // Address decode. The IO register wins over RAM when enabled; when it
    // is disabled its address always decodes as out of range.
    // ------------------------------------------------------------------
`ifdef MEM_IOPORT_EN
    assign w_is_io  = (w_addr == IO_ADDR);
    assign w_in_ram = !w_is_io && ({1'b0, w_addr} < c_RAM_LIMIT);
`else
    assign w_is_io  = 1'b0;
    assign w_in_ram = (w_addr != IO_ADDR) && ({1'b0, w_addr} < c_RAM_LIMIT);
`endif
    assign w_oob = !w_in_ram && !w_is_io;
    assign w_idx = w_addr[c_AW-1:0];

    // ------------------------------------------------------------------
    // Commit: read data, out-of-range flag and IO register. r_oob is only
    // set on the commit edge, so it is high exactly in the RESP cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= 8'h00;
            r_oob   <= 1'b0;
            r_io    <= 8'h00;
        end else begin
            r_oob <= w_commit && w_oob;
            if (w_commit) begin
                if (w_rw) begin
                    if (w_is_io) begin
                        r_rdata <= r_io;
                    end else if (w_in_ram) begin
                        r_rdata <= r_mem[w_idx];
                    end else begin
                        r_rdata <= 8'hFF;
                    end
                end else if (w_is_io) begin
                    r_io <= w_wdata;
                end
            end
        end
    end

    // RAM array has no reset; writes are suppressed while reset is held so
    // an access caught by reset leaves memory untouched.
    always_ff @(posedge clk) begin
        if (rst_n && w_commit && !w_rw && w_in_ram) begin
            r_mem[w_idx] <= w_wdata;
        end
    end

    assign rdata_o = r_rdata;
    assign oob_o   = r_oob;
`ifdef MEM_IOPORT_EN
    assign io_o    = r_io;
`endif

endmodule
`default_nettype wire
